// File: rtl/hcp_arb_pkg.sv
// Shared constants for the host-control-path input arbiter: packet tag
// encodings, FSM state encoding and the default packet word width.
package hcp_arb_pkg;

  localparam int DATA_W_DEF = 134;

  // Packet tag in the top two bits of every word.
  localparam logic [1:0] TAG_SINGLE = 2'b00;
  localparam logic [1:0] TAG_HEAD   = 2'b01;
  localparam logic [1:0] TAG_TAIL   = 2'b10;
  localparam logic [1:0] TAG_MID    = 2'b11;

  // Arbiter FSM state encoding.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARB  = 2'd1;
  localparam logic [1:0] ST_XFER = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  // A word that may legally start a packet.
  function automatic logic is_start(input logic [1:0] tag);
    return (tag == TAG_HEAD) || (tag == TAG_SINGLE);
  endfunction

  // A word that closes a packet.
  function automatic logic is_end(input logic [1:0] tag);
    return (tag == TAG_TAIL) || (tag == TAG_SINGLE);
  endfunction

endpackage

// File: rtl/hcp_rr_grant.sv
// Combinational round-robin priority select: the first requester found
// searching upward from last_grant+1 (mod NUM_PORT) wins.
module hcp_rr_grant #(
  parameter int NUM_PORT = 4,
  parameter int IDX_W    = $clog2(NUM_PORT)
) (
  input  logic [NUM_PORT-1:0] req,
  input  logic [IDX_W-1:0]    last_grant,
  output logic [IDX_W-1:0]    grant,
  output logic                grant_valid
);

  // Walk from the farthest candidate to the nearest so the nearest one wins.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] sel;
    grant       = '0;
    grant_valid = 1'b0;
    idx         = 0;
    sel         = '0;
    for (int i = NUM_PORT; i >= 1; i--) begin
      idx = int'(last_grant) + i;
      if (idx >= NUM_PORT) idx = idx - NUM_PORT;
      sel = IDX_W'(idx);
      if (req[sel]) begin
        grant       = sel;
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hcp_input_arbiter.sv
// Per-packet round-robin arbiter: grants one show-ahead packet FIFO, drains
// exactly one packet onto the shared registered output tagged with its source
// port, and drops orphan words (no preceding head) left in a FIFO.
// Optional statistics counters are built when HCP_ARB_STAT_EN is defined.
module hcp_input_arbiter
  import hcp_arb_pkg::*;
#(
  parameter int NUM_PORT = 4,
  parameter int DATA_W   = DATA_W_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NUM_PORT*DATA_W-1:0] iv_pkt_data,
  input  logic [NUM_PORT-1:0]      i_pkt_empty,
  output logic [NUM_PORT-1:0]      o_pkt_rd,
  input  logic                     i_out_ready,
  output logic [DATA_W-1:0]        ov_data,
  output logic                     o_data_wr,
  output logic [3:0]               ov_pkt_inport,
  output logic                     o_discard_pulse,
  output logic [NUM_PORT*16-1:0]   ov_pkt_cnt,
  output logic [15:0]              ov_discard_cnt
);

  localparam int IDX_W = $clog2(NUM_PORT);

  logic [1:0]          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, last_grant_q;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [NUM_PORT-1:0] req;
  logic [DATA_W-1:0]   arb_word, cur_word;
  logic [1:0]          arb_tag, cur_tag;
  logic                pop, xfer_pop, drop_pop;

  assign req = ~i_pkt_empty;

  hcp_rr_grant #(
    .NUM_PORT (NUM_PORT),
    .IDX_W    (IDX_W)
  ) u_rr_grant (
    .req         (req),
    .last_grant  (last_grant_q),
    .grant       (arb_idx),
    .grant_valid (arb_valid)
  );

  // Head word of the arbitration winner and of the currently granted queue.
  assign arb_word = iv_pkt_data[arb_idx*DATA_W +: DATA_W];
  assign cur_word = iv_pkt_data[grant_q*DATA_W +: DATA_W];
  assign arb_tag  = arb_word[DATA_W-1 -: 2];
  assign cur_tag  = cur_word[DATA_W-1 -: 2];

  // Next-state and pop decision; pops are always gated by non-empty.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!arb_valid)              state_d = ST_IDLE;
        else if (is_start(arb_tag))  state_d = ST_XFER;
        else                         state_d = ST_DROP;
      end
      ST_XFER: begin
        pop = ~i_pkt_empty[grant_q] & i_out_ready;
        if (pop && is_end(cur_tag)) state_d = ST_IDLE;
      end
      ST_DROP: begin
        // Stop without popping once a legal packet start (or nothing) is at the head.
        if (i_pkt_empty[grant_q] || is_start(cur_tag)) state_d = ST_ARB;
        else                                           pop     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign xfer_pop = pop && (state_q == ST_XFER);
  assign drop_pop = pop && (state_q == ST_DROP);

  // One-hot pop towards the granted queue.
  always_comb begin
    o_pkt_rd          = '0;
    o_pkt_rd[grant_q] = pop;
  end

  // FSM state, grant bookkeeping and source-port tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      last_grant_q  <= IDX_W'(NUM_PORT - 1);
      ov_pkt_inport <= 4'd0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_ARB && arb_valid) begin
        grant_q       <= arb_idx;
        ov_pkt_inport <= 4'(arb_idx);
      end
      if (xfer_pop && is_end(cur_tag)) last_grant_q <= grant_q;
    end
  end

  // Registered output word; holds the last word when nothing is popped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_data         <= '0;
      o_data_wr       <= 1'b0;
      o_discard_pulse <= 1'b0;
    end else begin
      if (xfer_pop) ov_data <= cur_word;
      o_data_wr       <= xfer_pop;
      o_discard_pulse <= drop_pop;
    end
  end

`ifdef HCP_ARB_STAT_EN
  logic [NUM_PORT*16-1:0] pkt_cnt_q;
  logic [15:0]            discard_cnt_q;

  // Forwarded-packet and discarded-word counters, wrapping at 16 bits.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pkt_cnt_q     <= '0;
      discard_cnt_q <= 16'd0;
    end else begin
      if (xfer_pop && is_end(cur_tag)) begin
        pkt_cnt_q[grant_q*16 +: 16] <= pkt_cnt_q[grant_q*16 +: 16] + 16'd1;
      end
      if (drop_pop) discard_cnt_q <= discard_cnt_q + 16'd1;
    end
  end

  assign ov_pkt_cnt     = pkt_cnt_q;
  assign ov_discard_cnt = discard_cnt_q;
`else
  assign ov_pkt_cnt     = '0;
  assign ov_discard_cnt = 16'd0;
`endif

endmodule

// File: doc/hcp_input_arbiter.md
# hcp_input_arbiter

Per-packet round-robin arbiter that shares the 134-bit host-side packet path between up to NUM_PORT frame-receive queues. Each queue is a show-ahead packet FIFO filled by one GMII input chain. The arbiter grants one queue, drains exactly one complete packet from it onto the shared output, tags that packet with its source port, and then moves on. It sits between the per-port packet FIFOs and the host control path, and replaces the one-port-only direct connection.

## Interface
Parameters:
- NUM_PORT, 4, number of requesting queues (2..8)
- DATA_W, 134, packet word width; [133:132] tag, [131:128] valid-byte field, [127:0] payload

Ports:
- i_clk  in  1  core clock
- i_rst  in  1  reset; asynchronous, active-high
- iv_pkt_data  in  NUM_PORT*DATA_W  show-ahead FIFO heads; port k occupies bits [k*DATA_W +: DATA_W]
- i_pkt_empty  in  NUM_PORT  per-queue FIFO empty
- o_pkt_rd  out  NUM_PORT  per-queue pop; one-hot or zero
- i_out_ready  in  1  downstream can accept a word this cycle (inverse of almost-full)
- ov_data  out  DATA_W  output word
- o_data_wr  out  1  ov_data valid
- ov_pkt_inport  out  4  source port of the current packet; stable from head to tail
- o_discard_pulse  out  1  one-cycle pulse per orphan word dropped
- ov_pkt_cnt  out  NUM_PORT*16  per-port forwarded-packet counters (see Configuration)
- ov_discard_cnt  out  16  discarded-word counter (see Configuration)

## Operation
Tag encoding in [133:132]:
- 01 = head
- 11 = middle
- 10 = tail
- 00 = single-word packet (head and tail)

State machine states are IDLE, ARB, XFER, DROP.
- **IDLE:** go to ARB when any i_pkt_empty bit is 0.
- **ARB:**
  - Search non-empty queues round-robin, starting at last_grant+1 mod NUM_PORT; record the winner as grant.
  - If the winner's head-word tag is 01 or 00, go to XFER.
  - Otherwise go to DROP.
  - No pop occurs in ARB.
- **XFER:**
  - o_pkt_rd[grant] = ~i_pkt_empty[grant] & i_out_ready.
  - Each pop registers the word onto ov_data, with o_data_wr=1 on the next cycle.
  - A popped word with tag 10 or 00 returns the FSM to IDLE, and last_grant <= grant.
  - If the queue goes empty mid-packet, the FSM stalls in XFER with no timeout. The packet is never interleaved with another port's packet.
- **DROP:**
  - Pops grant's words while they are non-empty, regardless of i_out_ready.
  - Each dropped word produces o_discard_pulse.
  - Stops after popping a word tagged 01 or 00 is NOT done. Instead, DROP exits to ARB, without popping, as soon as the head tag of the FIFO is 01 or 00 or the FIFO is empty.
  - last_grant is unchanged, so the same port is re-evaluated first only by normal rotation.
- ov_pkt_inport = grant, zero-extended; it is loaded in ARB.

## Timing
- Reset values: o_pkt_rd=0, ov_data=0, o_data_wr=0, ov_pkt_inport=0, o_discard_pulse=0, counters=0, state=IDLE, last_grant=NUM_PORT-1 (so port 0 is checked first).
- Latency: pop in cycle n produces o_data_wr in cycle n+1. Data is registered once, with no combinational path from iv_pkt_data to ov_data.
- Packet gap: tail pop in n, IDLE n+1, ARB n+2, first pop of next packet n+3.
- i_out_ready is sampled combinationally into o_pkt_rd. When i_out_ready=0, no pop occurs and the output holds the last word with o_data_wr=0.
- The pop condition is always ANDed with ~i_pkt_empty. Popping an empty FIFO is illegal.
- If reset is asserted mid-packet, all state clears immediately. Partially drained FIFO contents are handled on restart by DROP.

## Configuration
- HCP_ARB_STAT_EN defined:
  - ov_pkt_cnt[k] increments on each forwarded tail/single word from port k.
  - ov_discard_cnt increments per dropped word.
  - Both counters are 16-bit and wrap at 0xFFFF->0.
- HCP_ARB_STAT_EN undefined: the counter ports stay present and are tied to 0, and no counter registers are built. o_discard_pulse is unaffected.

## Structure
- Package hcp_arb_pkg holds:
  - tag constants TAG_HEAD, TAG_MID, TAG_TAIL, TAG_SINGLE
  - state encoding
  - DATA_W default
- Sub-module hcp_rr_grant: combinational round-robin priority select.
  - Inputs: request vector, last_grant.
  - Outputs: grant index and grant_valid.
- The FSM, output register and counters live in the top.

## Test plan
- **Fairness:** ports 0–3 each hold three 4-word packets, i_out_ready=1 → output port order is 0,1,2,3,0,1,2,3,0,1,2,3; 48 o_data_wr pulses; 3-cycle inter-packet gap.
- **Backpressure:** port 2 sends a 6-word packet while i_out_ready toggles 1,0,1,0… → six words arrive intact and in order, no pop while ready=0, ov_pkt_inport=2 throughout.
- **Mid-packet starvation:** port 1 provides head+mid, then stays empty for 50 cycles while port 3 is non-empty → no port-3 word appears until port 1's tail has been output.
- **Orphan drop:** port 0 FIFO starts with mid, mid, tail, then a valid 2-word packet → 3 o_discard_pulse, ov_discard_cnt=3 (STAT_EN), then the 2-word packet is forwarded.
- **Single-word packets:** 10 tag-00 words on port 3 only → 10 outputs; ov_pkt_cnt[3]=10; ov_pkt_cnt[3] wraps to 0 after 65536.
- **Reset mid-XFER:** assert i_rst during word 3 of 8 → all outputs 0 next edge; after release, the remaining 5 words are dropped and the next head is forwarded.
